rr_arbiter16: RTL and testbench

- Round-robin arbiter sharing one resource between 16 requesters.
- Registers a 4-bit winner index and drives a one-hot 16-bit grant bus produced by the existing 4-to-16 decoder.
- Holds each grant until the grantee releases, withdraws its request, or the hold timeout expires.
- Sits in front of any shared datapath slot that needs one owner per cycle.

---
 rtl/rr_arbiter16_pkg.sv | 13 +
 rtl/rr_arbiter16_decoder.sv | 14 +
 rtl/rr_arbiter16.sv | 112 +++++++++++
 tb/tb_rr_arbiter16.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter16_pkg.sv
// Shared types and sizing constants for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter16_decoder.sv
// Existing 4-to-16 binary-to-one-hot decoder used to build the grant bus.
module decoder4to16
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: one owner among 16 requesters, held until release,
// withdrawal or HOLD_MAX expiry, with one dead cycle between grants.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               release_i,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout
);

  localparam bit               HOLD_EN  = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_e              state_q, state_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic                timeout_q, timeout_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W-1:0]     winner;
  logic                 expired;
  logic [NUM_REQ-1:0]   dec_onehot;

  decoder4to16 u_dec (
    .idx    (grant_idx_q),
    .onehot (dec_onehot)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[NUM_REQ-1:0];
    offset  = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_rot[i-1]) offset = IDX_W'(i - 1);
    end
    winner  = ptr_q + offset;
    expired = HOLD_EN && (hold_cnt_q == HOLD_LIM);
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    timeout_d     = 1'b0;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d       = ST_GRANT;
          grant_valid_d = 1'b1;
          grant_idx_d   = winner;
          hold_cnt_d    = HOLD_W'(1);
          ptr_d         = winner + 1'b1;
        end
      end
      ST_GRANT: begin
        if (release_i || !req[grant_idx_q] || expired) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          // Release and withdrawal take precedence, so only a pure expiry pulses.
          timeout_d     = !release_i && req[grant_idx_q] && expired;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    grant_valid = grant_valid_q;
    grant_idx   = grant_idx_q;
    timeout     = timeout_q;
    grant       = dec_onehot & {NUM_REQ{grant_valid_q}};
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: a HOLD_MAX=4 instance and an unlimited-hold
// instance share stimulus; each scenario checks the instance it targets.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        release_i;

  logic        gv, to, gv0, to0;
  logic [3:0]  gi, gi0;
  logic [15:0] g, g0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  rr_arbiter16 #(.HOLD_MAX(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
    .grant_valid (gv),
    .grant_idx   (gi),
    .grant       (g),
    .timeout     (to)
  );

  rr_arbiter16 #(.HOLD_MAX(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
    .grant_valid (gv0),
    .grant_idx   (gi0),
    .grant       (g0),
    .timeout     (to0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    release_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] one = 16'h0001;
  int unsigned exp_rr [4] = '{0, 15, 0, 15};

  initial begin
    do_reset();
    tick();
    check("rst_gv",  16'(gv), 16'd0);
    check("rst_gi",  16'(gi), 16'd0);
    check("rst_g",   g,       16'h0000);
    check("rst_to",  16'(to), 16'd0);

    // Reset mid-grant of idx 5, then confirm ptr returned to 0.
    req = 16'h0020;
    tick();
    check("pre_rst_gi", 16'(gi), 16'd5);
    check("pre_rst_g",  g,       16'h0020);
    rst = 1'b1;
    tick();
    check("midrst_gv", 16'(gv), 16'd0);
    check("midrst_g",  g,       16'h0000);
    check("midrst_to", 16'(to), 16'd0);
    rst = 1'b0;
    req = 16'h0041;
    tick();
    check("post_rst_g", g, 16'h0001);
    release_i = 1'b1;
    req       = '0;
    tick();
    release_i = 1'b0;

    // Single requester with release and regrant after one dead cycle.
    do_reset();
    req = 16'h0010;
    tick();
    check("single_gi", 16'(gi), 16'd4);
    check("single_g",  g,       16'h0010);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    check("single_rel_g", g, 16'h0000);
    tick();
    check("single_regrant_g", g, 16'h0010);
    release_i = 1'b1;
    req       = '0;
    tick();
    release_i = 1'b0;
    tick();
    check("idle_rel_ignored_gv", 16'(gv), 16'd0);

    // Round-robin wrap between 0 and 15.
    do_reset();
    req = 16'h8001;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_gi", k), 16'(gi), 16'(exp_rr[k]));
      check($sformatf("rr%0d_g", k),  g,       one << exp_rr[k]);
      tick();
      check($sformatf("rr%0d_hold", k), g, one << exp_rr[k]);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check($sformatf("rr%0d_dead", k), 16'(gv), 16'd0);
      tick();
    end
    release_i = 1'b1;
    req       = '0;
    tick();
    release_i = 1'b0;

    // Timeout with HOLD_MAX=4; the unlimited instance must keep its grant.
    do_reset();
    req = 16'h0004;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_cyc%0d_g", c),  g,       16'h0004);
      check($sformatf("to_cyc%0d_to", c), 16'(to), 16'd0);
    end
    tick();
    check("to_dead_gv",  16'(gv),  16'd0);
    check("to_pulse",    16'(to),  16'd1);
    check("unl_gv",      16'(gv0), 16'd1);
    check("unl_to",      16'(to0), 16'd0);
    tick();
    check("to_regrant_g", g,       16'h0004);
    check("to_pulse_end", 16'(to), 16'd0);
    tick();
    tick();
    tick();
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    check("rel_vs_to_gv", 16'(gv), 16'd0);
    check("rel_vs_to_to", 16'(to), 16'd0);
    req = '0;
    tick();

    // Unlimited hold survives far past any finite limit.
    do_reset();
    req = 16'h0002;
    for (int c = 0; c < 300; c++) tick();
    check("unl_long_gi", 16'(gi0), 16'd1);
    check("unl_long_gv", 16'(gv0), 16'd1);
    check("unl_long_to", 16'(to0), 16'd0);
    req = '0;
    tick();

    // Withdraw and release together, then ptr-driven pick of 8 over 3.
    do_reset();
    req = 16'h0008;
    tick();
    check("wr_gi", 16'(gi), 16'd3);
    req       = 16'h0100;
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    check("wr_gv", 16'(gv), 16'd0);
    check("wr_to", 16'(to), 16'd0);
    req = 16'h0108;
    tick();
    check("wr_next_gi", 16'(gi), 16'd8);
    req = 16'h0008;
    tick();
    check("withdraw_gv", 16'(gv), 16'd0);
    check("withdraw_to", 16'(to), 16'd0);
    tick();
    check("withdraw_next_gi", 16'(gi), 16'd3);
    req = '0;
    tick();

    // All requesting, release after one cycle: strict 0..15,0 order.
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      tick();
      check($sformatf("all%0d_gi", k),     16'(gi0), 16'(k % 16));
      check($sformatf("all%0d_g", k),      g0,       one << (k % 16));
      check($sformatf("all%0d_onehot", k), 16'($onehot(g0)), 16'd1);
      check($sformatf("all%0d_g4", k),     g,        one << (k % 16));
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      check($sformatf("all%0d_dead", k), g0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
